// File: rtl/load_store_unit.sv
// Load/store unit: turns one MEM-stage request into a single aligned word bus
// transaction, with lane steering, load extension, fault detection and stall.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       lane_q;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the narrow datum across every lane so byte enables alone pick the target.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[8*a +: 8];
    h = d[16*a[1] +: 16];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b010:  return d;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  assign stall = ((state == IDLE) && req_valid) || (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      funct3_q  <= 3'd0;
      lane_q    <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      fault     <= FAULT_NONE;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (is_illegal(req_we, req_funct3)) begin
              fault     <= FAULT_ILLEGAL;
              rsp_rdata <= 32'd0;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else if (is_misaligned(req_funct3[1:0], req_addr[1:0])) begin
              fault     <= FAULT_MISALIGN;
              rsp_rdata <= 32'd0;
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_we ? store_data(req_funct3[1:0], req_wdata) : 32'd0;
              mem_be    <= req_we ? store_be(req_funct3[1:0], req_addr[1:0]) : 4'b1111;
              funct3_q  <= req_funct3;
              lane_q    <= req_addr[1:0];
              cnt       <= '0;
              state     <= BUSY;
            end
          end
        end
        // An ack on the same cycle the counter tops out still completes the access.
        BUSY: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            fault     <= FAULT_NONE;
            rsp_rdata <= mem_we ? 32'd0 : load_extend(funct3_q, lane_q, mem_rdata);
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == CNT_MAX) begin
            mem_req   <= 1'b0;
            fault     <= FAULT_TIMEOUT;
            rsp_rdata <= 32'd0;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests checked
// against an arithmetic model of the access rules.
module tb_load_store_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // observations of the last transaction
  bit          obs_got, obs_stable, obs_req_at_rsp, obs_stall_at_rsp;
  int          obs_rsp_cyc, obs_stall, obs_busy;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_we;
  logic [1:0]  obs_fault;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

  // Reference rules: legality, natural alignment, lane offsets via arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input bit timed_out,
                       output logic [1:0] e_fault, output logic [31:0] e_rdata,
                       output logic [3:0] e_be, output logic [31:0] e_wdata, output bit e_bus);
    bit legal;
    int nbytes, off;
    longint v, span;
    legal  = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    nbytes = 1 << (int'(f3) % 4);
    off    = int'(addr % 32'd4);
    e_bus  = legal && (off % nbytes == 0);
    e_fault = !legal ? 2'd3 : !e_bus ? 2'd1 : timed_out ? 2'd2 : 2'd0;
    e_be    = we ? 4'(((1 << nbytes) - 1) << off) : 4'd15;
    if (nbytes == 1)      e_wdata = (wdata % 256) * 32'h0101_0101;
    else if (nbytes == 2) e_wdata = (wdata % 65536) * 32'h0001_0001;
    else                  e_wdata = wdata;
    e_rdata = 32'd0;
    if (!we && e_fault == 2'd0) begin
      span = 64'd1 << (8 * nbytes);
      v = (longint'(rdata) >> (8 * off)) % span;
      if (f3 < 3'd4 && nbytes < 4 && v >= span / 2) v = v - span;
      e_rdata = v[31:0];
    end
  endtask

  // Drives one request and records what the DUT does; ack_at<0 means never ack.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at);
    bit first = 1;
    obs_got = 0; obs_rsp_cyc = -1; obs_stall = 0; obs_busy = 0; obs_stable = 1;
    obs_addr = 0; obs_wdata = 0; obs_be = 0; obs_we = 0; obs_rdata = 0; obs_fault = 0;
    obs_req_at_rsp = 0; obs_stall_at_rsp = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_ack = 0; mem_rdata = rdata;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (rsp_valid) begin
        obs_got = 1; obs_rsp_cyc = c; obs_rdata = rsp_rdata; obs_fault = fault;
        obs_req_at_rsp = mem_req; obs_stall_at_rsp = stall;
        break;
      end
      if (stall) obs_stall++;
      if (mem_req) begin
        if (first) begin
          obs_addr = mem_addr; obs_wdata = mem_wdata; obs_be = mem_be; obs_we = mem_we;
        end else if (obs_addr !== mem_addr || obs_wdata !== mem_wdata ||
                     obs_be !== mem_be || obs_we !== mem_we) begin
          obs_stable = 0;
        end
        first = 0;
        mem_ack = (ack_at >= 0 && obs_busy == ack_at);
        obs_busy++;
      end else begin
        mem_ack = 0;
      end
      @(negedge clk);
    end
    req_valid = 0; mem_ack = 0;
  endtask

  task automatic test_reset;
    rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    #1;
    checks++;
    if ({mem_req, mem_we, rsp_valid, stall, mem_addr, mem_wdata, mem_be, rsp_rdata, fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b rv=%b st=%b addr=%h wd=%h be=%b rd=%h f=%b required all 0",
               mem_req, mem_we, rsp_valid, stall, mem_addr, mem_wdata, mem_be, rsp_rdata, fault);
    end
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_lw_basic;
    run_txn(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0);
    checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h required 00000100", obs_addr); end
    checks++; if (obs_be !== 4'b1111) begin errors++; $display("FAIL lw_be: got %b required 1111", obs_be); end
    checks++; if (obs_stall != 2) begin errors++; $display("FAIL lw_stall_cycles: got %0d required 2", obs_stall); end
    checks++; if (obs_rsp_cyc != 2) begin errors++; $display("FAIL lw_latency: got %0d required 2", obs_rsp_cyc); end
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h required deadbeef", obs_rdata); end
    checks++; if (obs_fault !== 2'b00) begin errors++; $display("FAIL lw_fault: got %b required 00", obs_fault); end
    checks++; if (obs_stall_at_rsp !== 1'b0) begin errors++; $display("FAIL lw_stall_in_done: got %b required 0", obs_stall_at_rsp); end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] ads [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exps[3] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, f3s[i], ads[i], 32'd0, 32'h80FF1234, 1);
      checks++;
      if (obs_rdata !== exps[i] || obs_fault !== 2'b00) begin
        errors++;
        $display("FAIL load_ext[%0d]: got rdata=%h fault=%b required rdata=%h fault=00",
                 i, obs_rdata, obs_fault, exps[i]);
      end
    end
  endtask

  task automatic test_stores;
    run_txn(1'b1, 3'b000, 32'h201, 32'h000000AB, 32'hFFFFFFFF, 0);
    checks++;
    if (obs_addr !== 32'h200 || obs_wdata !== 32'hABABABAB || obs_be !== 4'b0010 ||
        obs_we !== 1'b1 || obs_rdata !== 32'd0 || obs_fault !== 2'b00) begin
      errors++;
      $display("FAIL sb: got addr=%h wd=%h be=%b we=%b rd=%h f=%b required 200 abababab 0010 1 0 00",
               obs_addr, obs_wdata, obs_be, obs_we, obs_rdata, obs_fault);
    end
    run_txn(1'b1, 3'b001, 32'h202, 32'h00001234, 32'd0, 2);
    checks++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'h12341234 || !obs_stable || obs_rsp_cyc != 4) begin
      errors++;
      $display("FAIL sh: got be=%b wd=%h stable=%0d lat=%0d required 1100 12341234 1 4",
               obs_be, obs_wdata, obs_stable, obs_rsp_cyc);
    end
  endtask

  task automatic test_faults;
    logic        wes [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
    logic [31:0] ads [4] = '{32'h102, 32'h100, 32'h001, 32'h003};
    logic [1:0]  exps[4] = '{2'b01, 2'b11, 2'b01, 2'b11};
    for (int i = 0; i < 4; i++) begin
      run_txn(wes[i], f3s[i], ads[i], 32'h55, 32'h12345678, 0);
      checks++;
      if (obs_fault !== exps[i] || obs_busy != 0 || obs_rsp_cyc != 1 || obs_rdata !== 32'd0) begin
        errors++;
        $display("FAIL fault[%0d]: got fault=%b bus_cycles=%0d lat=%0d rd=%h required %b 0 1 0",
                 i, obs_fault, obs_busy, obs_rsp_cyc, obs_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 3'b010, 32'h40, 32'd0, 32'h0, -1);
    checks++;
    if (!obs_got || obs_busy != TMO + 1 || obs_fault !== 2'b10 || obs_req_at_rsp !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got rsp=%0d req_cycles=%0d fault=%b req_at_rsp=%b required 1 %0d 10 0",
               obs_got, obs_busy, obs_fault, obs_req_at_rsp, TMO + 1);
    end
    run_txn(1'b0, 3'b010, 32'h44, 32'd0, 32'hCAFEF00D, TMO);
    checks++;
    if (obs_busy != TMO + 1 || obs_fault !== 2'b00 || obs_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL ack_at_limit: got req_cycles=%0d fault=%b rd=%h required %0d 00 cafef00d",
               obs_busy, obs_fault, obs_rdata, TMO + 1);
    end
  endtask

  task automatic test_reset_mid_busy;
    int seen = 0;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h300; mem_ack = 0;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_busy_req: got %b required 1", mem_req); end
    rst = 1; req_valid = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got req=%b stall=%b rv=%b required 0 0 0", mem_req, stall, rsp_valid);
    end
    @(negedge clk); rst = 0;
    repeat (4) begin @(negedge clk); #1; if (rsp_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL no_rsp_after_reset: got %0d pulses required 0", seen); end
    run_txn(1'b0, 3'b001, 32'h106, 32'd0, 32'h8001_0000, 0);
    checks++;
    if (obs_rdata !== 32'hFFFF8001 || obs_fault !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_lh: got rd=%h f=%b required ffff8001 00", obs_rdata, obs_fault);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h10; mem_rdata = 32'h1111_2222;
    @(negedge clk); #1; mem_ack = 1;
    @(negedge clk); #1; mem_ack = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11112222) begin errors++; $display("FAIL b2b_first: got rv=%b rd=%h required 1 11112222", rsp_valid, rsp_rdata); end
    req_we = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0BAD_F00D;
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got req=%b stall=%b rv=%b required 0 1 0", mem_req, stall, rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL b2b_second_bus: got req=%b we=%b addr=%h wd=%h required 1 1 20 0badf00d",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1;
    @(negedge clk); #1; mem_ack = 0; req_valid = 0;
    checks++; if (rsp_valid !== 1'b1 || fault !== 2'b00 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL b2b_second_rsp: got rv=%b f=%b rd=%h required 1 00 0", rsp_valid, fault, rsp_rdata); end
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata, e_rdata, e_wdata;
    logic [1:0]  e_fault;
    logic [3:0]  e_be;
    bit          e_bus;
    int          ack_at, e_lat;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'(((1 << (int'(f3) % 4)) - 1));
      ack_at = $urandom_range(0, 3);
      model(we, f3, addr, wdata, rdata, 1'b0, e_fault, e_rdata, e_be, e_wdata, e_bus);
      run_txn(we, f3, addr, wdata, rdata, ack_at);
      e_lat = e_bus ? ack_at + 2 : 1;
      checks++;
      if (obs_fault !== e_fault || obs_rdata !== e_rdata || obs_rsp_cyc != e_lat ||
          obs_busy != (e_bus ? ack_at + 1 : 0)) begin
        errors++;
        $display("FAIL rand_rsp[%0d] we=%b f3=%b addr=%h: got f=%b rd=%h lat=%0d bus=%0d required f=%b rd=%h lat=%0d bus=%0d",
                 i, we, f3, addr, obs_fault, obs_rdata, obs_rsp_cyc, obs_busy,
                 e_fault, e_rdata, e_lat, e_bus ? ack_at + 1 : 0);
      end
      if (e_bus) begin
        checks++;
        if (obs_addr !== {addr[31:2], 2'b00} || obs_be !== e_be || obs_we !== we ||
            (we && obs_wdata !== e_wdata) || !obs_stable) begin
          errors++;
          $display("FAIL rand_bus[%0d] we=%b f3=%b addr=%h: got a=%h be=%b we=%b wd=%h st=%0d required be=%b wd=%h",
                   i, we, f3, addr, obs_addr, obs_be, obs_we, obs_wdata, obs_stable, e_be, e_wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_lw_basic;
    test_load_ext;
    test_stores;
    test_faults;
    test_timeout;
    test_reset_mid_busy;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MEM stage of the 5-stage RV32I pipeline and a handshaked data-memory bus. It replaces the single-cycle combinational data-memory access.
- Converts an EX/MEM load/store request into an aligned word bus transaction with byte enables.
- Performs lane steering, sign/zero extension and fault detection.
- Stalls the pipeline until the access completes.

Parameters:
- TIMEOUT, 255, max cycles to wait for mem_ack in BUSY before raising a bus-timeout fault (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  MEM stage holds a load or store; held stable while stall=1
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data, right-aligned
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- fault  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3; valid with rsp_valid
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  bus completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  bus read word

Behaviour:
- Reset (async): state=IDLE. mem_req, mem_we, rsp_valid, stall-contributing state, timeout counter, mem_addr, mem_wdata, mem_be, rsp_rdata and fault all 0. A reset mid-transaction drops mem_req immediately; no response is issued.
- stall = (state==IDLE && req_valid) || state==BUSY. This is combinational and deasserts in DONE so the pipeline advances exactly once.
- FSM states: IDLE, BUSY, DONE.
- IDLE, req_valid=1, legal and aligned:
  - Register mem_we, mem_addr, mem_wdata, mem_be, funct3 and addr[1:0].
  - Next state BUSY; counter cleared.
- IDLE, req_valid=1, illegal or misaligned:
  - No bus cycle.
  - Next state DONE with the fault code registered.
- BUSY:
  - mem_req=1, all bus outputs held stable.
  - On mem_ack: capture the steered mem_rdata and go to DONE, fault=00.
  - Otherwise increment the counter. If the counter reaches TIMEOUT, go to DONE with fault=10.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT, mem_ack wins.
- DONE: rsp_valid=1 for one cycle, mem_req=0, then return to IDLE unconditionally. A new request is accepted no earlier than the following IDLE cycle.
- Minimum latency (mem_ack in the first BUSY cycle): accept at cycle 0, ack at cycle 1, rsp_valid at cycle 2. stall is high in cycles 0-1.
- Alignment rules: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any funct3 other than 000, 001, 010.
  - Checked before alignment; illegal takes precedence over misaligned.
- Store steering:
  - SB: wdata = {4{wdata[7:0]}}, be = 1<<addr[1:0].
  - SH: wdata = {2{wdata[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: be = 1111.
- Load bus cycle: be=1111, mem_we=0.
- Load extraction:
  - Byte lane = mem_rdata[8*addr[1:0] +: 8]; half lane = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- Timeout counter width is clog2(TIMEOUT+1) and it saturates; it does not wrap.
- rsp_rdata and fault hold their values until the next DONE. They are meaningful only while rsp_valid=1.

Test Plan:
- LW addr=0x100, mem_ack on the first BUSY cycle with mem_rdata=0xDEADBEEF:
  - mem_addr=0x100, be=1111.
  - stall high for 2 cycles.
  - rsp_valid at cycle 2, rsp_rdata=0xDEADBEEF, fault=00.
- LB addr=0x103 with mem_rdata=0x80FF1234 -> rsp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr=0x102 -> 0x000080FF.
- SB addr=0x201 with wdata=0x000000AB -> mem_addr=0x200, mem_wdata=0xABABABAB, be=0010, mem_we=1, rsp_rdata=0. SH addr=0x202 with wdata=0x1234 -> be=1100, mem_wdata=0x12341234.
- LW addr=0x102 -> no mem_req ever, rsp_valid the cycle after the request, fault=01. Load funct3=011 -> fault=11. SH funct3=001 at addr=0x001 -> fault=01.
- TIMEOUT=4 with mem_ack held low -> mem_req high for 4+1 cycles, then rsp_valid with fault=10 and mem_req low. A repeat run with mem_ack arriving on the count-reaching cycle -> fault=00.
- rst pulsed mid-BUSY -> mem_req, stall and rsp_valid go to 0 asynchronously, no rsp_valid follows, and the next request completes normally.
